// File: rtl/extern_rf_multiport.sv
// extern_rf_multiport
// Configurable multi-port register file for CGRA tiles. A serial config chain
// fills a shadow register, and Config_Load copies it into the active config.
// For each write port the active config holds an enable and an address. For
// each read port it holds an address and a bypass bit. Storage is written
// synchronously. Reads are combinational and can optionally forward the data
// being written in the same cycle.
module extern_rf_multiport #(
    parameter int NUM_IN  = 1,
    parameter int NUM_OUT = 2,
    parameter int DEPTH   = 2,
    parameter int WIDTH   = 32
) (
    input  logic                     CGRA_Clock,
    input  logic                     CGRA_Reset,
    input  logic                     Config_Enable,
    input  logic                     Config_Load,
    input  logic                     ConfigIn,
    output logic                     ConfigOut,
    input  logic                     CGRA_Enable,
    input  logic [NUM_IN*WIDTH-1:0]  in,
    output logic [NUM_OUT*WIDTH-1:0] out
);

    // Address width is at least one bit, even for a two-entry file.
    localparam int AW       = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int WP_BITS  = 1 + AW;           // WE, then write address
    localparam int RP_BITS  = AW + 1;           // read address, then bypass
    localparam int RD_BASE  = NUM_IN * WP_BITS;
    localparam int CFG_BITS = RD_BASE + NUM_OUT * RP_BITS;

    // DEPTH at address width + 1, so that an out-of-range address compares cleanly.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [CFG_BITS-1:0] sr_reg;
    logic [CFG_BITS-1:0] active_reg;

    logic [WIDTH-1:0] mem_reg  [DEPTH];
    logic [WIDTH-1:0] mem_next [DEPTH];

    logic [NUM_IN-1:0]  we;
    logic [AW-1:0]      addr_i [NUM_IN];
    logic [WIDTH-1:0]   wdata  [NUM_IN];
    logic [AW-1:0]      addr_o [NUM_OUT];
    logic [NUM_OUT-1:0] byp;

    // Split the active config into the fields of each write port.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_wr_fields
            assign we[gi]     = active_reg[gi*WP_BITS];
            assign addr_i[gi] = active_reg[gi*WP_BITS+1 +: AW];
            assign wdata[gi]  = in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Split the active config into the fields of each read port.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_rd_fields
            assign addr_o[gi] = active_reg[RD_BASE + gi*RP_BITS +: AW];
            assign byp[gi]    = active_reg[RD_BASE + gi*RP_BITS + AW];
        end
    endgenerate

    // Shadow chain shift and commit. A load captures the shadow value from before
    // this edge's shift.
    always_ff @(posedge CGRA_Clock) begin
        if (CGRA_Reset) begin
            sr_reg     <= '0;
            active_reg <= '0;
        end else begin
            if (Config_Load) begin
                active_reg <= sr_reg;
            end
            if (Config_Enable) begin
                sr_reg <= {ConfigIn, sr_reg[CFG_BITS-1:1]};
            end
        end
    end

    // The chain tail comes straight from a flop, so ConfigIn never reaches it
    // combinationally.
    assign ConfigOut = sr_reg[0];

    // Contents the file will hold after this edge. Ports are applied in ascending
    // order, so the highest-index port wins an address collision. Writes to
    // addresses past the last entry are dropped.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_next[e] = mem_reg[e];
        end
        if (CGRA_Enable) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (we[k] && ({1'b0, addr_i[k]} < DEPTH_W)) begin
                    mem_next[addr_i[k]] = wdata[k];
                end
            end
        end
    end

    // Storage update. Reset clears every entry.
    always_ff @(posedge CGRA_Clock) begin
        if (CGRA_Reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_reg[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_reg[e] <= mem_next[e];
            end
        end
    end

    // Read ports. A bypassed read looks at mem_next, so the forwarded value is the
    // same as the value that will be stored. An out-of-range address reads as zero.
    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_rd_port
            logic             rd_ok;
            logic [WIDTH-1:0] rd_data;

            assign rd_ok = ({1'b0, addr_o[gi]} < DEPTH_W);

            // Select the stored value or the forwarded value for this port.
            always_comb begin
                rd_data = '0;
                if (rd_ok) begin
                    if (byp[gi]) begin
                        rd_data = mem_next[addr_o[gi]];
                    end else begin
                        rd_data = mem_reg[addr_o[gi]];
                    end
                end
            end

            assign out[gi*WIDTH +: WIDTH] = rd_data;
        end
    endgenerate

endmodule
